// File: rtl/mul_pkg.sv
// Shared types and default sizing for the multiply sequencer.
package mul_pkg;

    localparam int unsigned MUL_WIDTH  = 24;
    localparam int unsigned MUL_PROD_W = 2 * MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_if.sv
// Decode-side handshake and product-register write bus of the multiply sequencer.
interface mul_if #(
    parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
) ();

    logic                 Start;
    logic                 Signed;
    logic [WIDTH-1:0]     OperandA;
    logic [WIDTH-1:0]     OperandB;
    logic                 ReadReq;
    logic                 Busy;
    logic                 Stall;
    logic                 Done;
    logic                 MulRegWrite;
    logic [2*WIDTH-1:0]   WriteData;

    modport master (
        output Start, Signed, OperandA, OperandB, ReadReq,
        input  Busy, Stall, Done, MulRegWrite, WriteData
    );

    modport slave (
        input  Start, Signed, OperandA, OperandB, ReadReq,
        output Busy, Stall, Done, MulRegWrite, WriteData
    );

endinterface

// File: rtl/mul_shift_add_step.sv
// One radix-2 step: conditionally add the multiplicand into the high half, then shift right.
module mul_shift_add_step
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] p_next_c
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        if (p[0]) begin
            sum = sum + {1'b0, a};
        end
        // Carry out of the add becomes the new MSB after the shift.
        p_next_c = {sum, p[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiply controller feeding the product register,
// with pipeline stall against new multiplies and product reads while busy.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic Clock,
    input  logic Reset,
    mul_if.slave bus
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    state_t              state;
    logic [WIDTH-1:0]    mag_a;
    logic                negate;
    logic [PROD_W-1:0]   p;
    logic [PROD_W-1:0]   p_step;
    logic [CNT_W-1:0]    step_cnt;
    logic                busy;
    logic                done;
    logic                wr_en;
    logic [PROD_W-1:0]   wr_data;
    logic [WIDTH-1:0]    mag_in_a;
    logic [WIDTH-1:0]    mag_in_b;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    always_comb begin
        mag_in_a = bus.OperandA;
        mag_in_b = bus.OperandB;
        if (bus.Signed && bus.OperandA[WIDTH-1]) begin
            mag_in_a = WIDTH'(0) - bus.OperandA;
        end
        if (bus.Signed && bus.OperandB[WIDTH-1]) begin
            mag_in_b = WIDTH'(0) - bus.OperandB;
        end
    end

    mul_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p        (p),
        .a        (mag_a),
        .p_next_c (p_step)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            mag_a    <= '0;
            negate   <= 1'b0;
            p        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mag_a    <= mag_in_a;
                        negate   <= bus.Signed & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                        p        <= {WIDTH'(0), mag_in_b};
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    p        <= p_step;
                    step_cnt <= step_cnt + CNT_W'(1);
                    // Final step: register the signed-corrected product for the WRITE cycle.
                    if (step_cnt == CNT_W'(WIDTH - 1)) begin
                        state   <= WRITE;
                        done    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_data <= negate ? (PROD_W'(0) - p_step) : p_step;
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.MulRegWrite = wr_en;
    assign bus.WriteData   = wr_data;
    assign bus.Stall       = busy & (bus.Start | bus.ReadReq);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: arithmetic reference model plus directed and random stimulus.
module tb_mul_sequencer;
    import mul_pkg::*;

    localparam int unsigned W  = 24;
    localparam int unsigned PW = 48;

    logic clk = 1'b0;
    logic rst;

    mul_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;
    int done_q[$];

    // Model: cycles since accept (0 = idle, W+1 = write cycle), expected product and register value.
    int            phase = 0;
    logic [PW-1:0] m_prod = '0;
    logic [PW-1:0] m_wd   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return PW'(x * y);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return W'(0);
            1:       return 24'h800000;
            2:       return 24'hFFFFFF;
            3:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            phase = 0;
            m_wd  = '0;
        end else if (phase == 0) begin
            if (bus.Start) begin
                phase  = 1;
                m_prod = ref_prod(bus.OperandA, bus.OperandB, bus.Signed);
            end
        end else if (phase == W + 1) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == W + 1) m_wd = m_prod;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  64'(bus.Busy),        64'(phase != 0));
            chk("write", 64'(bus.MulRegWrite), 64'(phase == W + 1));
            chk("done",  64'(bus.Done),        64'(phase == W + 1));
            chk("wdata", 64'(bus.WriteData),   64'(m_wd));
            chk("stall", 64'(bus.Stall),       64'((phase != 0) && (bus.Start || bus.ReadReq)));
            if (bus.Done) done_q.push_back(cyc);
        end
    end

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [PW-1:0] exp, input string name, input int hold, input bit rd);
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Signed = s; bus.OperandA = a; bus.OperandB = b; bus.ReadReq = rd;
        @(negedge clk);
        chk({name, "_accept_stall"}, 64'(bus.Stall), 64'(0));
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            bus.Start    = (k <= hold);
            bus.ReadReq  = rd && (k == 3 || k == W + 1);
            bus.OperandA = W'($urandom);
            bus.OperandB = W'($urandom);
            bus.Signed   = 1'($urandom);
            @(negedge clk);
            chk({name, "_busy"},  64'(bus.Busy),        64'(1));
            chk({name, "_write"}, 64'(bus.MulRegWrite), 64'(k == W + 1));
            if (k == W + 1) begin
                chk({name, "_product"}, 64'(bus.WriteData), 64'(exp));
                chk({name, "_done"},    64'(bus.Done),      64'(1));
            end
            if (bus.Start || bus.ReadReq) chk({name, "_stall_busy"}, 64'(bus.Stall), 64'(1));
        end
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.ReadReq = 1'b1;
        @(negedge clk);
        chk({name, "_idle_busy"},  64'(bus.Busy),        64'(0));
        chk({name, "_idle_write"}, 64'(bus.MulRegWrite), 64'(0));
        chk({name, "_idle_stall"}, 64'(bus.Stall),       64'(0));
        chk({name, "_hold"},       64'(bus.WriteData),   64'(exp));
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.ReadReq = 1'b1;
        bus.OperandA = '0; bus.OperandB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  64'(bus.Busy),        64'(0));
        chk("rst_stall", 64'(bus.Stall),       64'(0));
        chk("rst_done",  64'(bus.Done),        64'(0));
        chk("rst_write", 64'(bus.MulRegWrite), 64'(0));
        chk("rst_wdata", 64'(bus.WriteData),   64'(0));
        bus.Start = 1'b0; bus.ReadReq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        do_mul(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, "u_max", 0, 1'b0);
        do_mul(24'hFFFFFD, 24'h000005, 1'b1, 48'hFFFFFFFFFFF1, "s_m3x5", 0, 1'b1);
        do_mul(24'h800000, 24'h800000, 1'b1, 48'h400000000000, "s_minmin", 0, 1'b0);
        do_mul(24'h800000, 24'h800000, 1'b0, 48'h400000000000, "u_half", 0, 1'b0);
        do_mul(24'h000000, 24'h123456, 1'b1, 48'h000000000000, "s_zero", 0, 1'b0);
        do_mul(24'h000000, 24'h123456, 1'b0, 48'h000000000000, "u_zero", 0, 1'b0);
        nd = done_q.size();
        do_mul(24'h000010, 24'h000003, 1'b0, 48'h000000000030, "hold_start", 6, 1'b1);
        chk("hold_single_write", 64'(done_q.size()), 64'(nd + 1));

        // Abort at step 10 of RUN: the product must never reach the register.
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.OperandA = 24'h000123; bus.OperandB = 24'h000456;
        bus.ReadReq = 1'b0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        nd  = done_q.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",  64'(bus.Busy),        64'(0));
        chk("abort_write", 64'(bus.MulRegWrite), 64'(0));
        repeat (40) @(posedge clk);
        chk("abort_no_write", 64'(done_q.size()), 64'(nd));
        do_mul(24'd7, 24'd6, 1'b0, 48'h00000000002A, "after_abort", 0, 1'b0);

        // Back-to-back: second Start raised in the WRITE cycle, accepted one cycle later.
        nd = done_q.size();
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.OperandA = 24'd5; bus.OperandB = 24'd5;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        bus.Start = 1'b1; bus.OperandA = 24'd3; bus.OperandB = 24'd3;
        @(negedge clk);
        chk("b2b_write_cycle", 64'(bus.MulRegWrite), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_gap_busy", 64'(bus.Busy), 64'(0));
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(negedge clk);
        chk("b2b_accept_busy", 64'(bus.Busy), 64'(1));
        repeat (30) @(posedge clk);
        chk("b2b_two_writes", 64'(done_q.size()), 64'(nd + 2));
        if (done_q.size() >= nd + 2)
            chk("b2b_interval", 64'(done_q[nd + 1] - done_q[nd]), 64'(26));
        chk("b2b_last_product", 64'(bus.WriteData), 64'(48'h9));

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        repeat (2000) begin
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 199) == 0);
            bus.Start    = ($urandom_range(0, 3) == 0);
            bus.ReadReq  = 1'($urandom);
            bus.Signed   = 1'($urandom);
            bus.OperandA = pick_operand();
            bus.OperandB = pick_operand();
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.Start = 1'b0; bus.ReadReq = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("final_idle", 64'(bus.Busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller for the 48-bit multiply product register of the 24-bit CPU. Accepts a multiply request from decode, runs a radix-2 shift-add sequence over 24 cycles (unsigned or signed), then issues the one-cycle write into the product register. While a multiply is in flight it stalls the pipeline against any new multiply or product read.

## Interface
- WIDTH, 24, operand width; product is 2*WIDTH bits.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; sampled on Clock.
- Start  in  1  request a multiply; accepted only in IDLE.
- Signed  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with Start.
- OperandA  in  WIDTH  multiplicand; sampled with Start.
- OperandB  in  WIDTH  multiplier; sampled with Start.
- ReadReq  in  1  decode wants to read the product register this cycle.
- Busy  out  1  high whenever state is not IDLE.
- Stall  out  1  Busy & (Start | ReadReq); combinational.
- Done  out  1  one-cycle pulse, coincident with MulRegWrite.
- MulRegWrite  out  1  write enable to the product register.
- WriteData  out  2*WIDTH  product to the product register.

## Operation
- States: IDLE, RUN, WRITE.
- IDLE: Start=1 latches |A|, |B| (magnitudes when Signed=1, raw otherwise), latches the negate flag = Signed & (A[msb] ^ B[msb]), loads P = {WIDTH'b0, |B|}, clears step counter, goes to RUN. Start=0 stays.
- RUN: per cycle, if P[0]: {c, P_hi} = P_hi + |A| (WIDTH+1-bit sum); then P = {c, P_hi, P_lo} >> 1. Counter increments; after WIDTH steps goes to WRITE.
- WRITE: MulRegWrite=1, Done=1, WriteData = negate ? -P : P (2*WIDTH-bit two's complement). Next state IDLE unconditionally.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable in WIDTH unsigned bits; no overflow possible in 2*WIDTH result.
- Start while Busy (RUN or WRITE): ignored, Stall=1; the requester holds Start until Stall drops and it is accepted in IDLE.
- ReadReq while Busy: Stall=1. ReadReq in IDLE: Stall=0 (register already holds the last product).
- Start and ReadReq together in IDLE: Start accepted, Stall=0 that cycle (read gets the old product).
- Operand inputs are ignored outside the Start-accept cycle.
- Reset in any state: next state IDLE, counter cleared, no write issued; an aborted product is never written.

## Timing
- Reset values: Busy=0, Stall=0, Done=0, MulRegWrite=0, WriteData=0; state IDLE.
- Start sampled at edge E0 -> RUN for edges E1..E(WIDTH) -> WRITE during the cycle after E(WIDTH) -> product register updated at edge E(WIDTH+1); with WIDTH=24, 25 edges from accept to register update.
- Busy high from the cycle after E0 through the WRITE cycle inclusive; back-to-back multiplies: next Start earliest accepted the cycle after WRITE (issue interval WIDTH+2 cycles).
- Done/MulRegWrite exactly one cycle wide; WriteData only meaningful while MulRegWrite=1, otherwise holds last value.
- Stall is combinational from Start/ReadReq and registered state; no combinational path from inputs to MulRegWrite/WriteData.

## Structure
- Shared package mul_pkg: state encoding typedef (IDLE, RUN, WRITE), default WIDTH constant (24), product width 2*WIDTH.
- Counter width $clog2(WIDTH+1).
- Optional sub-module mul_shift_add_step: combinational one-step add-and-shift on P; everything else stays in mul_sequencer.

## Test plan
- Unsigned 0xFFFFFF x 0xFFFFFF -> MulRegWrite pulse 25 edges after accept, WriteData=0xFFFFFE000001, Done coincident.
- Signed -3 (0xFFFFFD) x 5 -> 0xFFFFFFFFFFF1; signed -2^23 x -2^23 (0x800000 both) -> 0x400000000000; unsigned 0x800000 x 0x800000 -> 0x400000000000.
- Zero operand: 0 x 0x123456 signed and unsigned -> 0x000000000000, timing unchanged.
- Hazards: Start held high while RUN -> Stall=1, no restart, single write; ReadReq in RUN and WRITE -> Stall=1; ReadReq in IDLE -> Stall=0; Start+ReadReq in IDLE -> accepted, Stall=0.
- Reset asserted at step 10 of RUN -> IDLE next edge, Busy=0, no MulRegWrite ever for that operation; following multiply 7 x 6 -> 0x00000000002A.
- Back-to-back: second Start held from WRITE cycle -> accepted the cycle after WRITE, two Done pulses 26 cycles apart.
